// File: rtl/cpu_pkg.sv
// Shared CPU front-end types and constants.
// Fetch state encoding and the {pc, instr} queue entry live here.
package cpu_pkg;

  localparam int XLEN = 32;
  localparam int ILEN = 32;
  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  typedef enum logic {
    FETCH_IDLE,
    FETCH_RUN
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] align_pc(
    input logic [XLEN-1:0] pc
  );
    return pc & ~XLEN'(3);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with flush and occupancy count.
// Storage is cleared on reset so the head reads zero until first push.
module sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  input  logic [WIDTH-1:0]           data_i,
  output logic [WIDTH-1:0]           data_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign do_push = push_i && (count != CW'(DEPTH));
  assign do_pop  = pop_i && (count != '0);

  assign data_o  = mem[rd_ptr];
  assign count_o = count;
  assign empty_o = (count == '0);

  // Pointer, count and storage update; flush drops all entries.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= data_i;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/instr_fetch_queue.sv
// Fetch front end: PC sequencing, credit-limited imem requests,
// stale-response dropping on redirect and a prefetch queue to decode.
module instr_fetch_queue
  import cpu_pkg::*;
#(
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_ready_i,
  input  logic            imem_valid_i,
  input  logic [ILEN-1:0] imem_data_i,
  output logic            instr_valid_o,
  output logic [ILEN-1:0] instr_o,
  output logic [XLEN-1:0] pc_o,
  input  logic            instr_ready_i
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0] CAP = (CW+1)'(DEPTH);

  fetch_state_e    state;
  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] resp_pc;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   drop_cnt;

  logic [CW-1:0]   count;
  logic            empty;
  logic [CW:0]     inflight;
  logic            accept;
  logic            push;
  logic            pop;
  fetch_entry_t    push_entry;
  fetch_entry_t    head;

  // Every queued or in-flight instruction holds one slot of credit,
  // so a response can never find the queue full.
  assign inflight = {1'b0, count} + {1'b0, outstanding};

  assign imem_req_o  = (state == FETCH_RUN) && !redirect_i
                     && (inflight < CAP);
  assign imem_addr_o = fetch_pc;
  assign accept      = imem_req_o && imem_ready_i;

  assign push = imem_valid_i && !redirect_i && (drop_cnt == '0);

  assign instr_valid_o = !empty && !redirect_i;
  assign pop           = instr_valid_o && instr_ready_i;

  assign push_entry.pc    = resp_pc;
  assign push_entry.instr = imem_data_i;

  assign instr_o = head.instr;
  assign pc_o    = head.pc;

  sync_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (redirect_i),
    .data_i  (push_entry),
    .data_o  (head),
    .count_o (count),
    .empty_o (empty)
  );

  // Run state: leaves IDLE on start, only reset returns it.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= FETCH_IDLE;
    end else if (state == FETCH_IDLE && start_i) begin
      state <= FETCH_RUN;
    end
  end

  // Next request address; advances on accept, reloads on redirect.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fetch_pc <= RESET_PC;
    end else if (redirect_i) begin
      fetch_pc <= align_pc(redirect_pc_i);
    end else if (accept) begin
      fetch_pc <= fetch_pc + PC_STEP;
    end
  end

  // PC tagged onto the next kept response.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      resp_pc <= RESET_PC;
    end else if (redirect_i) begin
      resp_pc <= align_pc(redirect_pc_i);
    end else if (push) begin
      resp_pc <= resp_pc + PC_STEP;
    end
  end

  // Requests accepted by memory but not yet answered.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      outstanding <= '0;
    end else begin
      case ({accept, imem_valid_i})
        2'b10:   outstanding <= outstanding + CW'(1);
        2'b01:   outstanding <= outstanding - CW'(1);
        default: outstanding <= outstanding;
      endcase
    end
  end

  // Responses still owed for fetches made before the last redirect;
  // a response landing in the redirect cycle is already discarded.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      drop_cnt <= '0;
    end else if (redirect_i) begin
      drop_cnt <= outstanding - CW'(imem_valid_i);
    end else if (imem_valid_i && drop_cnt != '0) begin
      drop_cnt <= drop_cnt - CW'(1);
    end
  end

endmodule

// File: doc/instr_fetch_queue.md
# instr_fetch_queue

Instruction fetch front end for the CPU: generates sequential PCs, issues requests to an instruction memory with a valid/ready request channel and in-order response channel, and buffers returned instructions with their PCs in a small prefetch queue. Decode consumes them through a valid/ready interface. A redirect input flushes the queue and in-flight fetches for taken branches and jumps. The block sits between instruction memory and the decode/Control stage, replacing the PC register, the PC+4 adder and the direct memory read.

## Interface
- DEPTH, 4: queue entries; power of two, ≥2
- RESET_PC, 32'h0000_0000: fetch PC after reset
- clk_i  in  1  clock; all state updates on rising edge
- rst_i  in  1  synchronous reset, active-high
- start_i  in  1  begin fetching; sampled only in IDLE
- redirect_i  in  1  flush and restart fetch at redirect_pc_i
- redirect_pc_i  in  32  new PC; bits [1:0] ignored, treated as 0
- imem_req_o  out  1  fetch request valid
- imem_addr_o  out  32  fetch address (word aligned)
- imem_ready_i  in  1  memory accepts request this cycle
- imem_valid_i  in  1  response valid; one per accepted request, in order, ≥1 cycle after acceptance
- imem_data_i  in  32  response instruction word
- instr_valid_o  out  1  queue head valid
- instr_o  out  32  queue head instruction
- pc_o  out  32  PC of queue head
- instr_ready_i  in  1  decode consumes head

## Operation
- States: IDLE (reset), RUN. IDLE→RUN when start_i=1; RUN left only by rst_i. start_i ignored in RUN.
- Registers: fetch_pc (next request address), resp_pc (PC of next non-dropped response), count (0..DEPTH), outstanding (0..DEPTH), drop_cnt (0..DEPTH).
- Request: imem_req_o = RUN && !redirect_i && (count + outstanding < DEPTH); imem_addr_o = fetch_pc. Accept = imem_req_o && imem_ready_i: fetch_pc += 4 (32-bit wrap), outstanding += 1.
- Once raised, imem_req_o and imem_addr_o stay stable until accepted; only redirect_i or rst_i may withdraw.
- Response: every imem_valid_i decrements outstanding. If drop_cnt > 0: discard, drop_cnt -= 1. Otherwise push {resp_pc, imem_data_i}; resp_pc += 4.
- Credit rule guarantees a push never finds the queue full; overflow is impossible by construction. Accept and response in the same cycle leave outstanding unchanged.
- Output: instr_valid_o = (count != 0) && !redirect_i. Pop = instr_valid_o && instr_ready_i. Push and pop in the same cycle leave count unchanged; push into an empty queue is visible the next cycle (no bypass).
- Redirect (any state): count ← 0; fetch_pc, resp_pc ← {redirect_pc_i[31:2],2'b00}; drop_cnt ← outstanding − (imem_valid_i ? 1 : 0). A response arriving in the redirect cycle is discarded. No request or pop occurs in the redirect cycle. In IDLE, redirect only sets the PCs.
- Back-to-back redirects: the later one wins; drop_cnt is recomputed from the current outstanding count.

## Timing
- Reset values: state IDLE, fetch_pc = resp_pc = RESET_PC, count = outstanding = drop_cnt = 0. Outputs: imem_req_o = 0, imem_addr_o = RESET_PC, instr_valid_o = 0, instr_o = 0, pc_o = 0.
- Reset mid-operation discards everything. The memory shares rst_i and returns no responses for pre-reset requests.
- Start latency: start_i at cycle n → imem_req_o at n+1.
- With a 1-cycle memory and ready held high: the first instruction is valid 2 cycles after the first request is accepted. Sustained throughput is 1 instruction/cycle when DEPTH ≥ memory latency + 1.
- Redirect at cycle n: the first request to the new PC is at n+1, and the earliest instr_valid_o for it is n+3 with a 1-cycle memory.

## Structure
- Shared package cpu_pkg: XLEN = 32, ILEN = 32, PC_STEP = 4, and the fetch state enum {FETCH_IDLE, FETCH_RUN}.
- Sub-module sync_fifo (parameters WIDTH, DEPTH) holding {pc, instr}: push/pop/flush/count, synchronous reset. Credit, drop and PC logic stay in instr_fetch_queue.

## Test plan
- Reset, start_i pulse, 1-cycle memory, ready always high → PCs 0x0, 0x4, 0x8… delivered in order, one per cycle from the third cycle after start.
- Decode stalls (instr_ready_i = 0) for 10 cycles → imem_req_o drops once count + outstanding = 4, there is no overflow, and the 4 queued entries drain in order.
- 3-cycle memory latency with imem_ready_i toggling → imem_addr_o holds stable while a request is unaccepted, and no PC is skipped or duplicated.
- Redirect to 0x103 with 2 requests outstanding → both stale responses are dropped, and the next pc_o is 0x100, then 0x104.
- Redirect in the same cycle as a response and a pop → the response is discarded, instr_valid_o = 0 in that cycle, and count = 0 the next cycle.
- rst_i asserted mid-stream → all outputs return to their reset values the next cycle, and no fetch occurs until the next start_i.
